// File: rtl/usb_fifo_ctrl.sv
// FX2LP synchronous slave-FIFO sequencer: bursts EP2 (host OUT) words into the rx stream
// and tx stream words into EP6 (host IN), with round-robin arbitration and timed PKTEND.
module usb_fifo_ctrl #(
  parameter int BURST_MAX      = 256,
  parameter int ADDR_SETTLE    = 2,
  parameter int PKTEND_TIMEOUT = 1024,
  parameter int PKT_WORDS      = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        usb_flagb,
  input  logic        usb_flagc,
  output logic        usb_slrd,
  output logic        usb_slwr,
  output logic        usb_sloe,
  output logic        usb_pktend,
  output logic [1:0]  usb_fifoaddr,
  input  logic [15:0] usb_fd_in,
  output logic [15:0] usb_fd_out,
  output logic        usb_fd_en,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [23:0] rx_count,
  output logic [23:0] tx_count
);

  localparam int IW = $clog2(PKTEND_TIMEOUT + 2);
  localparam int PW = $clog2(PKT_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, RD_SEL, RD_BURST, RD_END, WR_SEL, WR_BURST, PKTEND, WR_END
  } state_t;

  state_t          state, nxt;
  logic [1:0]      fifoaddr_q;
  logic [3:0]      settle_q;
  logic [15:0]     burst_q;
  logic            last_wr_q;
  logic [PW-1:0]   pkt_words_q;
  logic [IW-1:0]   idle_q;

  logic rd_go, wr_go, burst_last, settled, pkt_due, pe_fire, rd_el, wr_el;

  // Strobes are combinational from state and flags so an async reset drops them at once.
  assign rd_go      = (state == RD_BURST) && usb_flagc && rx_ready;
  assign wr_go      = (state == WR_BURST) && usb_flagb && tx_valid;
  assign burst_last = (burst_q == 16'(BURST_MAX - 1));
  assign settled    = (settle_q == 4'(ADDR_SETTLE));
  assign pkt_due    = (PKTEND_TIMEOUT != 0) && (pkt_words_q != '0) &&
                      (idle_q == IW'(PKTEND_TIMEOUT));
  assign pe_fire    = (state == PKTEND) && usb_flagb;
  assign rd_el      = rx_ready;
  assign wr_el      = tx_valid || pkt_due;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (rd_el && (!wr_el || last_wr_q)) nxt = RD_SEL;
        else if (wr_el)                     nxt = WR_SEL;
      end
      RD_SEL:   if (settled) nxt = usb_flagc ? RD_BURST : IDLE;
      RD_BURST: if (!usb_flagc || !rx_ready || (rd_go && burst_last)) nxt = RD_END;
      RD_END:   nxt = IDLE;
      WR_SEL:   if (settled) nxt = WR_BURST;
      WR_BURST: begin
        // A PKTEND is only taken on a cycle that did not itself write a word.
        if (!usb_flagb || !tx_valid || (wr_go && burst_last))
          nxt = (pkt_due && !wr_go) ? PKTEND : WR_END;
      end
      PKTEND:   if (usb_flagb) nxt = WR_END;
      WR_END:   nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fifoaddr_q  <= 2'b00;
      settle_q    <= '0;
      burst_q     <= '0;
      last_wr_q   <= 1'b1;
      pkt_words_q <= '0;
      idle_q      <= '0;
      rx_count    <= '0;
      tx_count    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == RD_SEL) fifoaddr_q <= 2'b00;
      if (state == IDLE && nxt == WR_SEL) fifoaddr_q <= 2'b10;
      if (state != nxt)   settle_q <= '0;
      else if (!settled)  settle_q <= settle_q + 4'd1;
      if (state == IDLE)        burst_q <= '0;
      else if (rd_go || wr_go)  burst_q <= burst_q + 16'd1;
      if ((state == RD_SEL && nxt == IDLE) || state == RD_END) last_wr_q <= 1'b0;
      else if (state == WR_END)                                last_wr_q <= 1'b1;
      // A full packet wraps to zero, so it never becomes a PKTEND candidate.
      if (pe_fire)    pkt_words_q <= '0;
      else if (wr_go) pkt_words_q <= (pkt_words_q == PW'(PKT_WORDS - 1)) ? '0 : pkt_words_q + 1'b1;
      if (wr_go || pe_fire) idle_q <= '0;
      else if (pkt_words_q != '0 && !tx_valid && idle_q != IW'(PKTEND_TIMEOUT))
        idle_q <= idle_q + 1'b1;
      if (rd_go) rx_count <= rx_count + 24'd1;
      if (wr_go) tx_count <= tx_count + 24'd1;
    end
  end

  // usb_fd_en is only high in write states and usb_sloe only low in RD_BURST, which are never adjacent.
  assign usb_slrd     = ~rd_go;
  assign usb_slwr     = ~wr_go;
  assign usb_sloe     = ~(state == RD_BURST);
  assign usb_pktend   = ~pe_fire;
  assign usb_fifoaddr = fifoaddr_q;
  assign usb_fd_out   = (state == WR_BURST) ? tx_data : 16'h0000;
  assign usb_fd_en    = (state == WR_BURST) || (state == PKTEND);
  assign rx_data      = usb_fd_in;
  assign rx_valid     = rd_go;
  assign tx_ready     = wr_go;

endmodule

// File: tb/tb_usb_fifo_ctrl.sv
// Bench for usb_fifo_ctrl: FX2 FIFO models plus local stream models, queue scoreboards on rx/EP6.
module tb_usb_fifo_ctrl;
  logic        clk = 1'b0, reset_n;
  logic        usb_flagb, usb_flagc, usb_slrd, usb_slwr, usb_sloe, usb_pktend, usb_fd_en;
  logic [1:0]  usb_fifoaddr;
  logic [15:0] usb_fd_in, usb_fd_out, rx_data, tx_data;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [23:0] rx_count, tx_count;

  logic [15:0] ep2_mem [0:1023];
  logic [15:0] tx_mem  [0:1023];
  int ep2_wp = 0, ep2_rp = 0, tx_wp = 0, tx_rp = 0, ep6_rcv = 0, cyc = 0;
  int ep6_limit = 2147483647;
  logic [15:0] rx_exp[$], tx_exp[$];
  int grants[$];
  bit rec_grants = 0;
  logic prev_sloe = 1'b1, prev_fd_en = 1'b0;
  int tests = 0, fails = 0, rd_strobes = 0, cur_rd = 0, max_rd = 0;
  int pkt_cycles = 0, last_pkt_cyc = 0, last_wr_cyc = 0;
  int b, p0, remaining;

  usb_fifo_ctrl #(.BURST_MAX(8), .ADDR_SETTLE(2), .PKTEND_TIMEOUT(16), .PKT_WORDS(16)) dut (
    .clk(clk), .reset_n(reset_n), .usb_flagb(usb_flagb), .usb_flagc(usb_flagc),
    .usb_slrd(usb_slrd), .usb_slwr(usb_slwr), .usb_sloe(usb_sloe), .usb_pktend(usb_pktend),
    .usb_fifoaddr(usb_fifoaddr), .usb_fd_in(usb_fd_in), .usb_fd_out(usb_fd_out),
    .usb_fd_en(usb_fd_en), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_count(rx_count), .tx_count(tx_count));

  always #10 clk = ~clk;

  // FX2 side: flags follow the addressed endpoint; EP6 can be made "full" after ep6_limit words.
  assign usb_flagc = (usb_fifoaddr == 2'b00) && (ep2_wp != ep2_rp);
  assign usb_flagb = (usb_fifoaddr == 2'b10) && (ep6_rcv < ep6_limit);
  assign usb_fd_in = ep2_mem[ep2_rp[9:0]];
  assign tx_valid  = (tx_wp != tx_rp);
  assign tx_data   = tx_mem[tx_rp[9:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!usb_slrd) ep2_rp  <= ep2_rp + 1;
    if (tx_ready)  tx_rp   <= tx_rp + 1;
    if (!usb_slwr) ep6_rcv <= ep6_rcv + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ep2_push(input logic [15:0] w);
    ep2_mem[ep2_wp[9:0]] = w; ep2_wp++; rx_exp.push_back(w);
  endtask

  task automatic tx_push(input logic [15:0] w);
    tx_mem[tx_wp[9:0]] = w; tx_wp++; tx_exp.push_back(w);
  endtask

  // One clock: sample everything at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    check("bus_contention", {63'd0, usb_fd_en & ~usb_sloe}, 64'd0);
    if (rx_valid) begin
      e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 16'hxxxx;
      check("rx_word", {46'd0, rx_ready, usb_flagc, rx_data}, {46'd0, 2'b11, e});
    end
    if (!usb_slwr) begin
      e = (tx_exp.size() != 0) ? tx_exp.pop_front() : 16'hxxxx;
      check("ep6_word", {45'd0, usb_flagb, tx_ready, usb_fd_en, usb_fd_out}, {45'd0, 3'b111, e});
      last_wr_cyc = cyc;
    end
    if (!usb_pktend) begin
      pkt_cycles++; last_pkt_cyc = cyc;
      check("pktend_cond", {60'd0, usb_slwr, usb_fifoaddr, usb_flagb}, 64'hD);
    end
    if (!usb_slrd) begin
      rd_strobes++; cur_rd++;
      if (cur_rd > max_rd) max_rd = cur_rd;
    end
    if (usb_sloe) cur_rd = 0;
    if (rec_grants) begin
      if (prev_sloe && !usb_sloe)   grants.push_back(0);
      if (!prev_fd_en && usb_fd_en) grants.push_back(1);
    end
    prev_sloe = usb_sloe; prev_fd_en = usb_fd_en;
    @(posedge clk); #1;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 3000 && rx_count != 24'(n); i++) tick();
    check("rx_count", {40'd0, rx_count}, 64'(n));
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 3000 && tx_count != 24'(n); i++) tick();
    check("tx_count", {40'd0, tx_count}, 64'(n));
  endtask

  function automatic int g(input int k);
    return (grants.size() > k) ? grants[k] : -1;
  endfunction

  initial begin
    reset_n = 1'b0; rx_ready = 1'b0;
    #1;
    check("rst_strobes", {60'd0, usb_slrd, usb_slwr, usb_sloe, usb_pktend}, 64'hF);
    check("rst_ctl", {59'd0, usb_fifoaddr, usb_fd_en, rx_valid, tx_ready}, 64'd0);
    check("rst_fd_out", {48'd0, usb_fd_out}, 64'd0);
    check("rst_counts", {16'd0, rx_count, tx_count}, 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Five-word EP2 read
    b = rd_strobes;
    for (int i = 1; i <= 5; i++) ep2_push(16'(i));
    rx_ready = 1'b1;
    wait_rx(5);
    repeat (10) tick();
    check("t1_strobes", 64'(rd_strobes - b), 64'd5);
    check("t1_sloe_high", {63'd0, usb_sloe}, 64'd1);
    rx_ready = 1'b0;
    tick();

    // Round-robin after reset: read, write, read
    reset_n = 1'b0;
    for (int i = 0; i < 20; i++) ep2_push(16'h2000 + 16'(i));
    for (int i = 0; i < 32; i++) tx_push(16'hA000 + 16'(i));
    rec_grants = 1; rx_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    wait_rx(20);
    wait_tx(32);
    rec_grants = 0;
    check("rr_grant0", 64'(g(0)), 64'd0);
    check("rr_grant1", 64'(g(1)), 64'd1);
    check("rr_grant2", 64'(g(2)), 64'd0);
    rx_ready = 1'b0;
    repeat (20) tick();

    // Short packet PKTEND, then a full packet with none
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    p0 = pkt_cycles;
    for (int i = 0; i < 3; i++) tx_push(16'hB000 + 16'(i));
    wait_tx(3);
    repeat (60) tick();
    check("pkt_one_pulse", 64'(pkt_cycles - p0), 64'd1);
    check("pkt_delay_min", {63'd0, (last_pkt_cyc - last_wr_cyc) >= 16}, 64'd1);
    check("pkt_delay_max", {63'd0, (last_pkt_cyc - last_wr_cyc) <= 30}, 64'd1);
    for (int i = 0; i < 16; i++) tx_push(16'hB100 + 16'(i));
    wait_tx(19);
    repeat (60) tick();
    check("pkt_full_none", 64'(pkt_cycles - p0), 64'd1);

    // EP6 full after 10 of 30 words
    reset_n = 1'b0;
    ep6_limit = ep6_rcv + 10;
    for (int i = 0; i < 30; i++) tx_push(16'hC000 + 16'(i));
    tick();
    reset_n = 1'b1;
    wait_tx(10);
    repeat (30) tick();
    check("flagb_hold", {40'd0, tx_count}, 64'd10);
    ep6_limit = 2147483647;
    wait_tx(30);
    repeat (40) tick();

    // rx_ready drop mid-burst, bursts capped at 8
    reset_n = 1'b0;
    for (int i = 0; i < 20; i++) ep2_push(16'h5000 + 16'(i));
    tick();
    reset_n = 1'b1;
    max_rd = 0; b = rd_strobes; rx_ready = 1'b1;
    for (int i = 0; i < 500 && (rd_strobes - b) < 3; i++) tick();
    rx_ready = 1'b0;
    #1;
    check("rdy_drop_slrd", {63'd0, usb_slrd}, 64'd1);
    repeat (5) tick();
    rx_ready = 1'b1;
    wait_rx(20);
    check("burst_max", {63'd0, max_rd <= 8}, 64'd1);
    check("rx_strobes", 64'(rd_strobes - b), 64'd20);
    rx_ready = 1'b0;
    repeat (5) tick();

    // Async reset during a write burst
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    for (int i = 0; i < 40; i++) tx_push(16'hD000 + 16'(i));
    for (int i = 0; i < 500 && usb_slwr; i++) tick();
    check("t6_in_burst", {63'd0, usb_slwr}, 64'd0);
    remaining = tx_exp.size();
    reset_n = 1'b0;
    #1;
    check("async_strobes", {61'd0, usb_slwr, usb_pktend, usb_sloe}, 64'h7);
    check("async_fd_en", {63'd0, usb_fd_en}, 64'd0);
    check("async_counts", {16'd0, rx_count, tx_count}, 64'd0);
    tick();
    reset_n = 1'b1;
    wait_tx(remaining);
    check("tx_drained", 64'(tx_exp.size()), 64'd0);
    check("rx_drained", 64'(rx_exp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
